// File: rtl/unidade_busca_pkg.sv
// -----------------------------------------------------------------------------
// unidade_busca_pkg
// Shared definitions for the instruction-fetch unit:
//   - state_t          : fetch FSM encoding (IDLE, FETCH, ISSUE)
//   - OP_*             : MIPS opcode constants seen by the control unit
//   - RESET_PC_DEFAULT : default program counter after reset
//   - branch_offset()  : sign-extended, word-scaled branch displacement
// -----------------------------------------------------------------------------
package unidade_busca_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_ISSUE = 2'b10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h00000000;

  // 16-bit immediate -> 32-bit byte displacement (sign-extend, then x4)
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/unidade_busca_proximo_pc.sv
// -----------------------------------------------------------------------------
// proximo_pc
// Combinational next-PC calculator.
// Inputs : pc (current instruction address), instr (current instruction),
//          Branch, Zero, Jump (control/ALU flags for the current instruction)
// Outputs: next_pc (address of the following instruction), pc_plus4
// Jump has priority over a taken branch. All arithmetic wraps modulo 2^32.
// -----------------------------------------------------------------------------
module proximo_pc
  import unidade_busca_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        Jump,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4
);

  // The opcode field is decoded by the control unit, not here.
  logic unused_op_bits;
  assign unused_op_bits = ^instr[31:26];

  // Next-PC selection: jump, then taken branch, then sequential.
  always_comb begin
    pc_plus4 = pc + 32'd4;
    if (Jump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (Branch && Zero) begin
      next_pc = pc_plus4 + branch_offset(instr[15:0]);
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/unidade_busca.sv
// -----------------------------------------------------------------------------
// unidade_busca
// Instruction-fetch unit: requests the word at pc, latches the returned
// instruction, presents it to decode/execute and advances pc on retire.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   imem_req/imem_addr  : read request to instruction memory (addr = pc)
//   imem_ack/imem_data  : memory response, data valid with ack
//   Branch, Jump, Zero  : control/ALU flags for the issued instruction
//   stall               : datapath cannot retire the issued instruction yet
//   instr, OP, Funct    : registered instruction word and its fields
//   instr_valid         : instr is live (ISSUE state)
//   pc, pc_plus4        : address of instr and that address + 4
// -----------------------------------------------------------------------------
module unidade_busca
  import unidade_busca_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Zero,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [5:0]  OP,
  output logic [5:0]  Funct,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] next_pc_s;

  // next_pc is only consumed on retire, so flags outside ISSUE have no effect.
  proximo_pc u_proximo_pc (
    .pc       (pc_q),
    .instr    (instr_q),
    .Branch   (Branch),
    .Zero     (Zero),
    .Jump     (Jump),
    .next_pc  (next_pc_s),
    .pc_plus4 (pc_plus4)
  );

  // FSM next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // Only here is an ack accepted; elsewhere it is dropped.
        if (imem_ack) begin
          instr_d = imem_data;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_ISSUE: begin
        if (!stall) begin
          pc_d    = next_pc_s;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Outputs are registered from the upcoming state so they line up with it.
    imem_req_d    = (state_d == ST_FETCH);
    instr_valid_d = (state_d == ST_ISSUE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h00000000;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign OP          = instr_q[31:26];
  assign Funct       = instr_q[5:0];
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;

endmodule

// File: doc/unidade_busca.md
UNIDADE_BUSCA -- requirements
Module: unidade_busca

Interface
REQ-001 Parameter: RESET_PC, 32'h00000000, PC value loaded on reset; SHALL be word-aligned (bits [1:0] = 0).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  byte address of the requested word; SHALL equal pc whenever imem_req=1.
REQ-006 imem_ack  input  1  memory response strobe; imem_data is valid in the same cycle.
REQ-007 imem_data  input  32  instruction word returned by memory.
REQ-008 Branch, Jump  input  1 each  from the control unit, decoded from the current OP.
REQ-009 Zero  input  1  ALU zero flag for the current instruction.
REQ-010 stall  input  1  datapath not ready to retire the current instruction.
REQ-011 instr  output  32  registered instruction word.
REQ-012 OP, Funct  output  6 each  instr[31:26] and instr[5:0], combinational slices of instr.
REQ-013 instr_valid  output  1  instr holds a live instruction for decode/execute.
REQ-014 pc, pc_plus4  output  32 each  address of instr, and pc+4.

Function
REQ-015 FSM states: IDLE, FETCH, ISSUE.
REQ-016 IDLE: imem_req=0; SHALL go to FETCH on the next clock.
REQ-017 FETCH: imem_req=1, imem_addr=pc held stable. On imem_ack=1 (same-cycle ack allowed): instr<=imem_data and state<=ISSUE. Otherwise remain in FETCH.
REQ-018 ISSUE: instr_valid=1, imem_req=0.
  - stall=1: hold pc, instr and state.
  - stall=0: pc<=next_pc; state<=FETCH.
  - Latency: ack-to-instr_valid is 1 cycle; retire-to-next-request is 1 cycle.
REQ-019 Next-PC rules, evaluated only in ISSUE:
  - Jump=1: next_pc = {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else Branch=1 and Zero=1: next_pc = pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  - else: next_pc = pc_plus4.
REQ-020 Jump SHALL take priority when Jump and Branch&Zero are both asserted.
REQ-021 Branch/Jump/Zero SHALL be ignored outside ISSUE or while stall=1.
REQ-022 imem_ack outside FETCH SHALL be ignored; instr SHALL NOT change.
REQ-023 All address arithmetic is 32-bit modulo 2^32: pc=32'hFFFFFFFC gives pc_plus4=0; branch targets wrap silently.
REQ-024 instr_valid SHALL be 0 in IDLE and FETCH.

Reset
REQ-025 When rst=1, regardless of clock: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0.
REQ-026 Reset mid-FETCH SHALL abandon the request; an ack arriving during or after reset, before the new FETCH, SHALL be discarded.
REQ-027 On rst deassertion, the first imem_req SHALL occur exactly one clock later (IDLE→FETCH).

Structure
REQ-028 The shared package SHALL hold:
  - the FSM state encoding;
  - opcode constants (R-type 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010);
  - the RESET_PC default.
REQ-029 The single sub-module SHALL be proximo_pc, a combinational next-PC calculator (pc, instr, Branch, Zero, Jump → next_pc, pc_plus4). The FSM and registers stay in the top module.

Verification
REQ-030 Reset then ack with 1-cycle latency: req at 0x0 → instr_valid=1 one cycle after ack; stall=0 → next req at 0x4.
REQ-031 BEQ at pc=0x10, imm=16'hFFFE, Branch=1, Zero=1 → next imem_addr=0x0C. Same with Zero=0 → 0x14.
REQ-032 J at pc=0x40000020, target field 26'h0000010 → next imem_addr=0x40000040. Jump=1 and Branch=Zero=1 together → jump target wins.
REQ-033 stall=1 for 3 cycles in ISSUE → pc, instr and instr_valid unchanged, imem_req=0; retires on the first stall=0 cycle.
REQ-034 Wrap: RESET_PC=32'hFFFFFFFC, sequential instruction → next imem_addr=0x0. Same-cycle ack at FETCH entry → instr_valid on the next cycle.
REQ-035 rst pulse mid-FETCH with ack 2 cycles later → ack ignored, instr=0, request restarts at RESET_PC one clock after rst falls.
